// File: rtl/chunked_sub_if.sv
// chunked_sub_if: operand/result bundle for the chunked subtractor.
//   in_valid, a, b        : request side, driven by the producer (master)
//   out_valid, out, borrow: result side, driven by the subtractor (slave)
// The subtractor has no backpressure, so there is no ready signal.
interface chunked_sub_if #(
    parameter int unsigned WIDTH = 32
);
    logic             in_valid;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic [WIDTH-1:0] out;
    logic             borrow;

    modport master (
        output in_valid, a, b,
        input  out_valid, out, borrow
    );

    modport slave (
        input  in_valid, a, b,
        output out_valid, out, borrow
    );
endinterface

// File: rtl/chunked_sub.sv
// chunked_sub: pipelined unsigned subtractor, out = (a - b) mod 2^WIDTH.
// One CHUNK-bit slice is resolved per stage, with the borrow registered between stages, so
// the per-cycle borrow chain is only CHUNK bits long. Latency NCHUNK cycles, one op per clock,
// no backpressure.
//   clk : rising-edge clock
//   rst : asynchronous, active-high reset; clears valid, borrow and result state
//   bus : chunked_sub_if slave modport (in_valid/a/b in, out_valid/out/borrow out)
module chunked_sub #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CHUNK = 8
) (
    input  logic          clk,
    input  logic          rst,
    chunked_sub_if.slave  bus
);
    if (CHUNK == 0 || (WIDTH % CHUNK) != 0) begin : g_bad_chunk
        $error("chunked_sub: WIDTH must be a nonzero multiple of CHUNK");
    end

    localparam int unsigned NCHUNK = WIDTH / CHUNK;
    // Stages that still have unprocessed operand slices to hand forward.
    localparam int unsigned NOPS   = (NCHUNK > 1) ? NCHUNK - 1 : 1;

    // Per-stage registered state, exported so the next stage can read it.
    logic [NCHUNK-1:0] st_valid;
    logic [NCHUNK-1:0] st_bout;
    logic [WIDTH-1:0]  st_res [NCHUNK];
    logic [WIDTH-1:0]  st_a   [NOPS];
    logic [WIDTH-1:0]  st_b   [NOPS];

    for (genvar k = 0; k < NCHUNK; k++) begin : g_stage
        logic             vin;
        logic             bin;
        logic [WIDTH-1:0] a_in;
        logic [WIDTH-1:0] b_in;
        logic [WIDTH-1:0] res_in;

        if (k == 0) begin : g_first
            assign vin    = bus.in_valid;
            assign bin    = 1'b0;
            assign a_in   = bus.a;
            assign b_in   = bus.b;
            assign res_in = '0;
        end else begin : g_next
            assign vin    = st_valid[k-1];
            assign bin    = st_bout[k-1];
            assign a_in   = st_a[k-1];
            assign b_in   = st_b[k-1];
            assign res_in = st_res[k-1];
        end

        logic             valid_d, valid_q;
        logic             bout_d, bout_q;
        logic [WIDTH-1:0] res_d, res_q;
        logic [CHUNK:0]   diff;

        // Operands arrive pre-shifted, so the slice for this stage always sits at the LSBs.
        always_comb begin
            diff    = {1'b0, a_in[CHUNK-1:0]} - {1'b0, b_in[CHUNK-1:0]}
                      - {{CHUNK{1'b0}}, bin};
            valid_d = vin;
            bout_d  = bout_q;
            res_d   = res_q;
            // Data regs only load on a real operation so out/borrow hold across bubbles.
            if (vin) begin
                bout_d                     = diff[CHUNK];
                res_d                      = res_in;
                res_d[k*CHUNK +: CHUNK]    = diff[CHUNK-1:0];
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                valid_q <= 1'b0;
                bout_q  <= 1'b0;
                res_q   <= '0;
            end else begin
                valid_q <= valid_d;
                bout_q  <= bout_d;
                res_q   <= res_d;
            end
        end

        assign st_valid[k] = valid_q;
        assign st_bout[k]  = bout_q;
        assign st_res[k]   = res_q;

        if (k < NCHUNK - 1) begin : g_ops
            logic [WIDTH-1:0] a_d, a_q;
            logic [WIDTH-1:0] b_d, b_q;

            always_comb begin
                a_d = a_q;
                b_d = b_q;
                if (vin) begin
                    a_d = a_in >> CHUNK;
                    b_d = b_in >> CHUNK;
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    a_q <= '0;
                    b_q <= '0;
                end else begin
                    a_q <= a_d;
                    b_q <= b_d;
                end
            end

            assign st_a[k] = a_q;
            assign st_b[k] = b_q;
        end
    end

    assign bus.out_valid = st_valid[NCHUNK-1];
    assign bus.out       = st_res[NCHUNK-1];
    assign bus.borrow    = st_bout[NCHUNK-1];
endmodule

// File: tb/tb_chunked_sub.sv
// Bench for chunked_sub: three instances (CHUNK = 8, 4, 16) share one stimulus stream.
// Expected results go into per-instance queues when issued; one monitor pops and compares
// whenever an instance presents out_valid, also checking the arrival cycle.
module tb_chunked_sub;
    localparam int unsigned W = 32;
    localparam int NDUT = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    chunked_sub_if #(.WIDTH(W)) if8 ();
    chunked_sub_if #(.WIDTH(W)) if4 ();
    chunked_sub_if #(.WIDTH(W)) if16 ();

    chunked_sub #(.WIDTH(W), .CHUNK(8))  u_dut8  (.clk(clk), .rst(rst), .bus(if8));
    chunked_sub #(.WIDTH(W), .CHUNK(4))  u_dut4  (.clk(clk), .rst(rst), .bus(if4));
    chunked_sub #(.WIDTH(W), .CHUNK(16)) u_dut16 (.clk(clk), .rst(rst), .bus(if16));

    typedef struct {
        logic [W-1:0] out;
        logic         borrow;
        int           cyc;
    } exp_t;

    exp_t sbq [NDUT][$];
    int   lat [NDUT] = '{4, 8, 2};
    int   cyc = 0;
    int   checks = 0;
    int   passes = 0;

    logic         ov  [NDUT];
    logic [W-1:0] od  [NDUT];
    logic         ob  [NDUT];
    assign ov[0] = if8.out_valid;  assign od[0] = if8.out;  assign ob[0] = if8.borrow;
    assign ov[1] = if4.out_valid;  assign od[1] = if4.out;  assign ob[1] = if4.borrow;
    assign ov[2] = if16.out_valid; assign od[2] = if16.out; assign ob[2] = if16.borrow;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor / scoreboard.
    always @(negedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NDUT; i++) begin
                if (ov[i]) begin
                    checks++;
                    if (sbq[i].size() == 0) begin
                        $display("FAIL unexpected_out dut%0d cyc %0d: got out=%h borrow=%b, required no output",
                                 i, cyc, od[i], ob[i]);
                    end else begin
                        exp_t e;
                        e = sbq[i].pop_front();
                        if (e.cyc != cyc || od[i] !== e.out || ob[i] !== e.borrow)
                            $display("FAIL result dut%0d: got out=%h borrow=%b cyc=%0d, required out=%h borrow=%b cyc=%0d",
                                     i, od[i], ob[i], cyc, e.out, e.borrow, e.cyc);
                        else
                            passes++;
                    end
                end else if (sbq[i].size() != 0 && sbq[i][0].cyc <= cyc) begin
                    exp_t e;
                    e = sbq[i].pop_front();
                    checks++;
                    $display("FAIL missing_out dut%0d: got out_valid=0 at cyc %0d, required out=%h borrow=%b",
                             i, cyc, e.out, e.borrow);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] req);
        checks++;
        if (got !== req) $display("FAIL %s: got %h, required %h", name, got, req);
        else passes++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive one cycle of input with an explicit expected result.
    task automatic drive_exp(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic [W-1:0] eo, input logic eb);
        if8.in_valid = v;  if8.a = a;  if8.b = b;
        if4.in_valid = v;  if4.a = a;  if4.b = b;
        if16.in_valid = v; if16.a = a; if16.b = b;
        if (v && !rst) begin
            for (int i = 0; i < NDUT; i++) begin
                exp_t e;
                e.out = eo;
                e.borrow = eb;
                e.cyc = cyc + lat[i];
                sbq[i].push_back(e);
            end
        end
    endtask

    // Reference model: plain modular arithmetic.
    task automatic drive(input logic v, input logic [W-1:0] a, input logic [W-1:0] b);
        longint unsigned diff;
        diff = {32'd0, a} - {32'd0, b};
        drive_exp(v, a, b, diff[W-1:0], (a < b));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            drive(1'b0, '0, '0);
            step();
        end
    endtask

    logic [W-1:0] da [11] = '{32'd1, 32'd3, 32'd7, 32'd4294967295, 32'd4294967295,
                              32'd4294967290, 32'd1234500000, 32'h100, 32'h0100_0000,
                              32'd0, 32'd5};
    logic [W-1:0] db [11] = '{32'd1, 32'd1, 32'd3, 32'd5, 32'd0, 32'd4, 32'd67890, 32'd1,
                              32'd1, 32'd1, 32'd7};
    logic [W-1:0] dexp [11] = '{32'd0, 32'd2, 32'd4, 32'd4294967290, 32'd4294967295,
                                32'd4294967286, 32'd1234432110, 32'hFF, 32'h00FF_FFFF,
                                32'hFFFF_FFFF, 32'hFFFF_FFFE};
    logic dbor [11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

    initial begin
        drive(1'b0, '0, '0);
        repeat (2) @(posedge clk);
        #1;
        chk("reset_out_valid8", {31'd0, if8.out_valid}, '0);
        chk("reset_out8", if8.out, '0);
        chk("reset_borrow8", {31'd0, if8.borrow}, '0);
        chk("reset_out_valid4", {31'd0, if4.out_valid}, '0);
        chk("reset_out_valid16", {31'd0, if16.out_valid}, '0);
        rst = 1'b0;

        // Directed values with bubbles between them.
        for (int i = 0; i < 11; i++) begin
            drive_exp(1'b1, da[i], db[i], dexp[i], dbor[i]);
            step();
            idle(1);
        end
        idle(10);

        // Streaming: 8 back-to-back, one bubble, 2 more.
        for (int i = 0; i < 11; i++) begin
            if (i == 8) drive(1'b0, $urandom, $urandom);
            else drive(1'b1, $urandom, $urandom);
            step();
        end
        idle(10);

        // Reset mid-flight.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, $urandom, $urandom);
            step();
        end
        drive(1'b1, $urandom, $urandom);
        #2;
        rst = 1'b1;
        #1;
        for (int i = 0; i < NDUT; i++) sbq[i].delete();
        chk("rst_out_valid8", {31'd0, if8.out_valid}, '0);
        chk("rst_out_valid4", {31'd0, if4.out_valid}, '0);
        chk("rst_out_valid16", {31'd0, if16.out_valid}, '0);
        chk("rst_out8", if8.out, '0);
        chk("rst_borrow8", {31'd0, if8.borrow}, '0);
        @(posedge clk);
        #1;
        drive(1'b1, $urandom, $urandom);
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        drive_exp(1'b1, 32'd3, 32'd1, 32'd2, 1'b0);
        step();
        idle(12);

        // Random traffic against the model.
        for (int n = 0; n < 10000; n++) begin
            logic [W-1:0] a, b;
            logic v;
            v = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 3))
                0: begin a = $urandom; b = $urandom; end
                1: begin a = $urandom_range(0, 15); b = $urandom_range(0, 15); end
                2: begin a = $urandom; b = a + $urandom_range(0, 4) - 2; end
                default: begin a = 32'hFFFF_FFFF - $urandom_range(0, 3);
                               b = $urandom_range(0, 1) ? 32'hFFFF_FFFF : $urandom; end
            endcase
            drive(v, a, b);
            step();
        end
        idle(12);

        for (int i = 0; i < NDUT; i++) begin
            checks++;
            if (sbq[i].size() != 0)
                $display("FAIL drain dut%0d: got %0d outstanding results, required 0", i,
                         sbq[i].size());
            else
                passes++;
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
